// File: rtl/main_mem_port_arbiter_pkg.sv
// Shared constants for the main memory port arbiter: owner encodings and the
// default starvation limit.
package main_mem_port_arbiter_pkg;

  localparam logic [1:0] OWNER_NONE  = 2'd0;
  localparam logic [1:0] OWNER_FETCH = 2'd1;
  localparam logic [1:0] OWNER_DATA  = 2'd2;

  localparam int STARVE_LIMIT_DEFAULT = 4;
  localparam int STARVE_CNT_W         = 4;

endpackage

// File: rtl/main_mem_arb_starve_counter.sv
// Saturating count of consecutive denied fetch cycles; limit_hit forces the
// next contended cycle to fetch.
module main_mem_arb_starve_counter
  import main_mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit = (cnt_q >= LIMIT);

endmodule

// File: rtl/main_mem_port_arbiter.sv
// Arbitrates one single-ported main memory between fetch and data requesters
// (data-first, starvation-bounded). Optional MAIN_MEM_ARB_STATS_EN adds grant/stall counters.
module main_mem_port_arbiter
  import main_mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MAIN_MEM_ARB_STATS_EN
  output logic [31:0]       fetch_grant_count,
  output logic [31:0]       data_grant_count,
  output logic [31:0]       fetch_stall_count,
`endif
  output logic [1:0]        owner
);

  logic              limit_hit;
  logic              fetch_stall;
  logic              fetch_rvalid_d, fetch_rvalid_q;
  logic              data_rvalid_d, data_rvalid_q;
  logic [DATA_W-1:0] fetch_rdata_d, fetch_rdata_q;
  logic [DATA_W-1:0] data_rdata_d, data_rdata_q;
  logic [1:0]        last_owner_d, last_owner_q;

  main_mem_arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr      (~fetch_stall),
    .inc      (fetch_stall),
    .limit_hit(limit_hit)
  );

  // Grant selection and memory drive: data wins unless fetch has starved.
  always_comb begin
    fetch_gnt = fetch_req & (~data_req | limit_hit);
    data_gnt  = data_req & ~fetch_gnt;
    owner     = OWNER_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    if (fetch_gnt) begin
      owner    = OWNER_FETCH;
      mem_addr = fetch_addr;
    end else if (data_gnt) begin
      owner     = OWNER_DATA;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_wen   = data_we;
    end
  end

  assign fetch_stall = fetch_req & ~fetch_gnt;

  // Return path: capture read data on the grant cycle, present it one cycle later.
  always_comb begin
    fetch_rvalid_d = fetch_gnt;
    fetch_rdata_d  = fetch_gnt ? mem_rdata : fetch_rdata_q;
    data_rvalid_d  = data_gnt & ~data_we;
    data_rdata_d   = (data_gnt & ~data_we) ? mem_rdata : data_rdata_q;
    last_owner_d   = owner;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      fetch_rdata_q  <= '0;
      data_rdata_q   <= '0;
      last_owner_q   <= OWNER_NONE;
    end else begin
      fetch_rvalid_q <= fetch_rvalid_d;
      data_rvalid_q  <= data_rvalid_d;
      fetch_rdata_q  <= fetch_rdata_d;
      data_rdata_q   <= data_rdata_d;
      last_owner_q   <= last_owner_d;
    end
  end

  assign fetch_rvalid = fetch_rvalid_q;
  assign data_rvalid  = data_rvalid_q;
  assign fetch_rdata  = fetch_rdata_q;
  assign data_rdata   = data_rdata_q;

  // last_owner is held for extensions only; reduce it so it is not left dangling.
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner_q;

`ifdef MAIN_MEM_ARB_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] fetch_grant_count_d, fetch_grant_count_q;
  logic [31:0] data_grant_count_d, data_grant_count_q;
  logic [31:0] fetch_stall_count_d, fetch_stall_count_q;

  always_comb begin
    fetch_grant_count_d = fetch_gnt ? sat_inc32(fetch_grant_count_q) : fetch_grant_count_q;
    data_grant_count_d  = data_gnt ? sat_inc32(data_grant_count_q) : data_grant_count_q;
    fetch_stall_count_d = fetch_stall ? sat_inc32(fetch_stall_count_q) : fetch_stall_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_grant_count_q <= '0;
      data_grant_count_q  <= '0;
      fetch_stall_count_q <= '0;
    end else begin
      fetch_grant_count_q <= fetch_grant_count_d;
      data_grant_count_q  <= data_grant_count_d;
      fetch_stall_count_q <= fetch_stall_count_d;
    end
  end

  assign fetch_grant_count = fetch_grant_count_q;
  assign data_grant_count  = data_grant_count_q;
  assign fetch_stall_count = fetch_stall_count_q;
`endif

endmodule

// File: tb/tb_main_mem_port_arbiter.sv
// Scoreboard bench for main_mem_port_arbiter: a reference model predicts grants
// and read data; a monitor pops expected read returns when rvalid is due.
module tb_main_mem_port_arbiter;
  import main_mem_port_arbiter_pkg::*;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_gnt, fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen;
  logic [1:0]  owner;
`ifdef MAIN_MEM_ARB_STATS_EN
  logic [31:0] fetch_grant_count, data_grant_count, fetch_stall_count;
`endif

  always #5 clk = ~clk;

  main_mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata),
`ifdef MAIN_MEM_ARB_STATS_EN
    .fetch_grant_count(fetch_grant_count), .data_grant_count(data_grant_count),
    .fetch_stall_count(fetch_stall_count),
`endif
    .owner(owner)
  );

  // Environment memory: combinational read, write at the clock edge.
  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;

  // Reference model state.
  logic [31:0] ref_mem [64];
  int m_starve = 0;
  typedef struct { int cyc; logic [31:0] d; } rd_t;
  rd_t fq[$];
  rd_t dq[$];
  int cyc_cnt = 0;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, advance the model.
  task automatic step(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd,
                      output logic fg, output logic dg);
    logic ef, ed;
    logic [1:0] eo;
    logic [31:0] ea, ewd;
    @(negedge clk);
    fetch_req = fr; fetch_addr = fa;
    data_req = dr; data_we = dw; data_addr = da; data_wdata = dwd;
    #1;
    if (fr && dr) begin
      ef = (m_starve >= LIM);
      ed = !ef;
    end else begin
      ef = fr;
      ed = dr;
    end
    eo  = ef ? OWNER_FETCH : (ed ? OWNER_DATA : OWNER_NONE);
    ea  = ef ? fa : (ed ? da : 32'd0);
    ewd = ed ? dwd : 32'd0;
    chk("fetch_gnt", fetch_gnt, ef);
    chk("data_gnt", data_gnt, ed);
    chk("owner", owner, eo);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wen", mem_wen, ed && dw);
    chk("mem_wdata", mem_wdata, ewd);
    if (rst) begin
      if (ef) fq.push_back('{cyc_cnt, ref_mem[fa[7:2]]});
      if (ed && !dw) dq.push_back('{cyc_cnt, ref_mem[da[7:2]]});
    end
    if (ed && dw) ref_mem[da[7:2]] = dwd;
    if (!rst || !fr || ef) m_starve = 0;
    else if (m_starve < LIM) m_starve++;
    fg = ef;
    dg = ed;
  endtask

  // Monitor: each cycle, a read return is due exactly when a grant was issued one cycle earlier.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_cnt++;
      if (fq.size() > 0 && fq[0].cyc == cyc_cnt - 1) begin
        chk("fetch_rvalid", fetch_rvalid, 1'b1);
        chk("fetch_rdata", fetch_rdata, fq[0].d);
        void'(fq.pop_front());
      end else begin
        chk("fetch_rvalid_idle", fetch_rvalid, 1'b0);
      end
      if (dq.size() > 0 && dq[0].cyc == cyc_cnt - 1) begin
        chk("data_rvalid", data_rvalid, 1'b1);
        chk("data_rdata", data_rdata, dq[0].d);
        void'(dq.pop_front());
      end else begin
        chk("data_rvalid_idle", data_rvalid, 1'b0);
      end
    end
  end

  initial begin
    logic fg, dg;
    logic fpr, dpr, dpw;
    logic [31:0] fpa, dpa, dpd;
    logic [9:0] pat;
    int run;
`ifdef MAIN_MEM_ARB_STATS_EN
    logic [31:0] fgc0, dgc0, fsc0;
`endif
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA5000000 + i;
      ref_mem[i] = 32'hA5000000 + i;
    end

    // Reset held low with random traffic.
    for (int i = 0; i < 5; i++) begin
      step($urandom_range(0, 1) == 1, {24'd0, 6'($urandom_range(0, 63)), 2'b00},
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, fg, dg);
    end
    @(negedge clk);
    fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_fetch_rvalid", fetch_rvalid, 1'b0);
    chk("rst_data_rvalid", data_rvalid, 1'b0);
    chk("rst_fetch_rdata", fetch_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_owner", owner, OWNER_NONE);
    chk("rst_mem_wen", mem_wen, 1'b0);

    // Fetch only.
    mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, fg, dg);
    @(posedge clk); #2;
    chk("fetch_only_rdata", fetch_rdata, 32'hDEADBEEF);

    // Contention: D,D,D,D,F,D,D,D,D,F.
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, dg);
`ifdef MAIN_MEM_ARB_STATS_EN
    fgc0 = fetch_grant_count; dgc0 = data_grant_count; fsc0 = fetch_stall_count;
`endif
    pat = 10'b1000010000;
    run = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, {24'd0, 6'(i + 8), 2'b00}, 1'b1, 1'b0, {24'd0, 6'(i + 32), 2'b00}, 32'h0, fg, dg);
      chk("contention_pattern", fg, pat[i]);
      run = fg ? 0 : run + 1;
      chk("contention_stall_bound", run > LIM, 1'b0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, dg);
`ifdef MAIN_MEM_ARB_STATS_EN
    chk("stats_data_grants", data_grant_count - dgc0, 32'd8);
    chk("stats_fetch_grants", fetch_grant_count - fgc0, 32'd2);
    chk("stats_fetch_stalls", fetch_stall_count - fsc0, 32'd8);
`endif

    // Store then load to the same address.
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234, fg, dg);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, fg, dg);
    @(posedge clk); #2;
    chk("store_load_rdata", data_rdata, 32'h1234);

    // Reset pulsed while a fetch read is outstanding.
    step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, fg, dg);
    void'(fq.pop_back());
    #1 rst = 1'b0;
    fetch_req = 1'b0;
    #1 rst = 1'b1;
    m_starve = 0;
    @(posedge clk); #2;
    chk("rst_mid_fetch_rvalid", fetch_rvalid, 1'b0);
    chk("rst_mid_fetch_rdata", fetch_rdata, 32'd0);

    // Randomized traffic; requesters hold their request until granted.
    fpr = 1'b0; dpr = 1'b0; dpw = 1'b0;
    fpa = '0; dpa = '0; dpd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!fpr) begin
        fpr = ($urandom_range(0, 99) < 65);
        fpa = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!dpr) begin
        dpr = ($urandom_range(0, 99) < 70);
        dpw = ($urandom_range(0, 1) == 1);
        dpa = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        dpd = $urandom;
      end
      step(fpr, fpa, dpr, dpw, dpa, dpd, fg, dg);
      if (fg) fpr = 1'b0;
      if (dg) dpr = 1'b0;
    end

    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, dg);
    chk("fetch_queue_drained", fq.size(), 0);
    chk("data_queue_drained", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
